// File: rtl/ota_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ota_pkg
// Brief    : Shared types and helpers for the OTA comparator post-processing.
// Revision : 1.0 - initial release
// ============================================================================
package ota_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [8:0] win_len(input logic [1:0] sel);
        logic [8:0] n;
        case (sel)
            2'd0:    n = 9'd32;
            2'd1:    n = 9'd64;
            2'd2:    n = 9'd128;
            default: n = 9'd256;
        endcase
        return n;
    endfunction

    // Last sample index of a window; N-1 always fits the 8-bit sample counter.
    function automatic logic [7:0] win_last(input logic [1:0] sel);
        logic [8:0] n_m1;
        n_m1 = win_len(sel) - 9'd1;
        return n_m1[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ota_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : ota_in_cond
// Brief    : Comparator input resynchroniser followed by a 2-of-3 deglitcher.
// Revision : 1.0 - initial release
// ============================================================================
module ota_in_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_in,
    output logic maj
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic [2:0]             r_taps;

    assign w_sync_d = {r_sync[SYNC_STAGES-2:0], cmp_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_taps <= 3'b000;
        end else begin
            r_sync <= w_sync_d;
            r_taps <= {r_taps[1:0], r_sync[SYNC_STAGES-1]};
        end
    end

    // A single-cycle pulse only ever occupies one tap, so it never wins the vote.
    assign maj = (r_taps[0] & r_taps[1]) |
                 (r_taps[1] & r_taps[2]) |
                 (r_taps[0] & r_taps[2]);

endmodule
`default_nettype wire

// File: rtl/ota_pdm_decimator.sv
`default_nettype none
// ============================================================================
// Module   : ota_pdm_decimator
// Brief    : Counts deglitched comparator ones over a programmable window and
//            hands the density word out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ota_pdm_decimator
    import ota_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic [1:0]       win_sel,
    input  logic             clr_ovr,
    output logic [CNT_W-1:0] density,
    output logic             dens_valid,
    input  logic             dens_ready,
    output logic             overrun,
    output logic             busy
);

    localparam logic [7:0] c_FILL_LAST = 8'(SYNC_STAGES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_fill_cnt;
    logic [CNT_W:0]   r_acc;
    logic [7:0]       r_smp_cnt;
    logic [7:0]       r_win_last;
    logic [CNT_W-1:0] r_density;
    logic             r_dens_valid;
    logic             r_overrun;

    logic             w_maj;
    logic             w_fill_done;
    logic             w_enter_run;
    logic             w_win_end;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_sat;

    ota_in_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_in (cmp_in),
        .maj    (w_maj)
    );

    assign w_fill_done = (r_state == FILL) && (r_fill_cnt == c_FILL_LAST);
    assign w_enter_run = w_fill_done && ena;
    assign w_win_end   = (r_state == RUN) && ena && (r_smp_cnt == r_win_last);

    // The accumulator can only reach 2^CNT_W, so the top bit alone flags saturation.
    assign w_sum = r_acc + {{CNT_W{1'b0}}, w_maj};
    assign w_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ena) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (!ena) begin
                    w_state_nxt = IDLE;
                end else if (w_fill_done) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!ena) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= 8'd0;
        end else if ((r_state == FILL) && ena && !w_fill_done) begin
            r_fill_cnt <= r_fill_cnt + 8'd1;
        end else begin
            r_fill_cnt <= 8'd0;
        end
    end

    // Leaving RUN for any reason throws the partial window away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_smp_cnt <= 8'd0;
        end else if ((r_state != RUN) || !ena || w_win_end) begin
            r_acc     <= '0;
            r_smp_cnt <= 8'd0;
        end else begin
            r_acc     <= w_sum;
            r_smp_cnt <= r_smp_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_last <= 8'd0;
        end else if (w_enter_run || w_win_end) begin
            r_win_last <= win_last(win_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_density    <= '0;
            r_dens_valid <= 1'b0;
        end else if (w_win_end) begin
            r_density    <= w_sat;
            r_dens_valid <= 1'b1;
        end else if (r_dens_valid && dens_ready) begin
            r_dens_valid <= 1'b0;
        end
    end

    // Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_win_end && r_dens_valid && !dens_ready) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign density    = r_density;
    assign dens_valid = r_dens_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ota_pdm_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ota_pdm_decimator
// Brief    : Directed self-checking bench for ota_pdm_decimator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ota_pdm_decimator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cmp_in;
    logic [1:0] win_sel;
    logic       clr_ovr;
    logic [7:0] density;
    logic       dens_valid;
    logic       dens_ready;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;   // 0: low, 1: high, 2: square period 8, 3: 1-cycle pulse every 5
    int edges;

    ota_pdm_decimator #(
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmp_in     (cmp_in),
        .win_sel    (win_sel),
        .clr_ovr    (clr_ovr),
        .density    (density),
        .dens_valid (dens_valid),
        .dens_ready (dens_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int phase;
        phase  = 0;
        cmp_in = 1'b0;
        forever begin
            @(negedge clk);
            phase = phase + 1;
            case (mode)
                1:       cmp_in = 1'b1;
                2:       cmp_in = ((phase % 8) < 4);
                3:       cmp_in = ((phase % 5) == 0);
                default: cmp_in = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until dens_valid is seen high just after one.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!dens_valid && cnt < 400);
        if (!dens_valid) begin
            check("valid_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        win_sel    = 2'd0;
        clr_ovr    = 1'b0;
        dens_ready = 1'b1;
        mode       = 1;
        step(4);
        check("rst_density", 32'(density), 32'd0);
        check("rst_valid",   32'(dens_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        rst_n = 1'b1;
        step(6);
        check("idle_busy", 32'(busy), 32'd0);

        // All ones, N=32
        ena = 1'b1;
        step(1);
        check("busy_fill", 32'(busy), 32'd1);
        wait_valid(edges);
        check("first_latency", 32'(edges + 1), 32'd37);
        check("ones32_density", 32'(density), 32'd32);
        wait_valid(edges);
        check("ones32_period", 32'(edges), 32'd32);
        check("ones32_density2", 32'(density), 32'd32);

        // 50% square wave, N=64
        win_sel = 2'd1;
        mode    = 2;
        wait_valid(edges);
        wait_valid(edges);
        check("sq_period", 32'(edges), 32'd64);
        check("sq_density", 32'(density >= 8'd31 && density <= 8'd33), 32'd1);
        wait_valid(edges);
        check("sq_density2", 32'(density >= 8'd31 && density <= 8'd33), 32'd1);

        // Saturation, N=256
        win_sel = 2'd3;
        mode    = 1;
        wait_valid(edges);
        wait_valid(edges);
        check("sat_period", 32'(edges), 32'd256);
        check("sat_density", 32'(density), 32'd255);

        // Glitch rejection, N=32
        win_sel = 2'd0;
        mode    = 3;
        wait_valid(edges);
        wait_valid(edges);
        check("glitch_density", 32'(density), 32'd0);
        wait_valid(edges);
        check("glitch_density2", 32'(density), 32'd0);

        // Backpressure: pending 0, then a 28-ones window overwrites it
        mode = 0;
        wait_valid(edges);
        wait_valid(edges);
        check("zero_density", 32'(density), 32'd0);
        dens_ready = 1'b0;
        mode       = 1;
        step(31);
        check("pending_no_ovr", 32'(overrun), 32'd0);
        check("pending_valid", 32'(dens_valid), 32'd1);
        check("pending_stable", 32'(density), 32'd0);
        step(1);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_density", 32'(density), 32'd28);
        dens_ready = 1'b1;
        step(1);
        check("accept_valid", 32'(dens_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr    = 1'b1;
        dens_ready = 1'b0;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        step(30);
        check("load_no_ovr_valid", 32'(dens_valid), 32'd1);
        check("load_no_ovr", 32'(overrun), 32'd0);
        check("load_density", 32'(density), 32'd32);
        step(31);
        clr_ovr = 1'b1;
        step(1);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        clr_ovr    = 1'b0;
        dens_ready = 1'b1;
        step(1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_clear2", 32'(overrun), 32'd0);
        wait_valid(edges);
        check("resume_period", 32'(edges), 32'd30);

        // Mid-window window-length change
        step(10);
        win_sel = 2'd2;
        wait_valid(edges);
        check("winsel_cur", 32'(edges), 32'd22);
        wait_valid(edges);
        check("winsel_next", 32'(edges), 32'd128);
        check("winsel_density", 32'(density), 32'd128);
        win_sel = 2'd0;
        wait_valid(edges);
        wait_valid(edges);
        check("winsel_back", 32'(edges), 32'd32);

        // Drop ena mid-window, then re-enable
        dens_ready = 1'b0;
        step(10);
        ena = 1'b0;
        step(1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_valid", 32'(dens_valid), 32'd1);
        check("drop_density", 32'(density), 32'd32);
        step(5);
        dens_ready = 1'b1;
        step(1);
        check("drop_accept", 32'(dens_valid), 32'd0);
        check("drop_keep_density", 32'(density), 32'd32);
        ena = 1'b1;
        wait_valid(edges);
        check("reena_latency", 32'(edges), 32'd37);
        check("reena_density", 32'(density), 32'd32);

        // Asynchronous reset with a pending, overrun result
        dens_ready = 1'b0;
        step(32);
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_density", 32'(density), 32'd0);
        check("arst_valid",   32'(dens_valid), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_busy",    32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
